// File: rtl/atr_sched.sv
// atr_sched: T/R switch and two-channel TX grant scheduler.
// Adds switch delays around each transmit burst and hands over between channels round-robin.
// The optional status outputs state_o and burst_cnt_o are built when ATR_SCHED_STATUS_EN is defined.
module atr_sched #(
    parameter int unsigned DW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic [1:0]    tx_empty_i,
    input  logic [DW-1:0] tx_delay_i,
    input  logic [DW-1:0] rx_delay_i,
    input  logic [DW-1:0] sw_delay_i,
    output logic          atr_tx_o,
    output logic [1:0]    grant_o
`ifdef ATR_SCHED_STATUS_EN
    ,
    output logic [2:0]    state_o,
    output logic [15:0]   burst_cnt_o
`endif
);

    localparam int unsigned BURST_W = 16;

    typedef enum logic [2:0] {
        ST_RX       = 3'd0,
        ST_TX_DELAY = 3'd1,
        ST_TX       = 3'd2,
        ST_SWITCH   = 3'd3,
        ST_RX_DELAY = 3'd4
    } state_t;

    state_t        state;
    logic [DW-1:0] count;
    logic          sel;
    logic          last;
    logic          pick_c;

    // Arbitration: the single pending channel, or the one not served last on a tie
    always_comb begin
        pick_c = ~last;
        case (tx_empty_i)
            2'b10:   pick_c = 1'b0;
            2'b01:   pick_c = 1'b1;
            default: pick_c = ~last;
        endcase
    end

    // Scheduler FSM; outputs are registered alongside every state change
    always_ff @(posedge clk_i) begin
        if (rst_i || !ena_i) begin
            state    <= ST_RX;
            count    <= '0;
            sel      <= 1'b0;
            last     <= 1'b1;
            atr_tx_o <= 1'b0;
            grant_o  <= 2'b00;
        end else begin
            case (state)
                ST_RX: begin
                    if (tx_empty_i != 2'b11) begin
                        sel   <= pick_c;
                        count <= tx_delay_i;
                        state <= ST_TX_DELAY;
                    end
                end
                ST_TX_DELAY: begin
                    if (count != '0) begin
                        count <= count - DW'(1);
                    end else begin
                        state    <= ST_TX;
                        atr_tx_o <= 1'b1;
                        grant_o  <= sel ? 2'b10 : 2'b01;
                    end
                end
                ST_TX: begin
                    if (tx_empty_i[sel]) begin
                        last    <= sel;
                        grant_o <= 2'b00;
                        if (!tx_empty_i[~sel]) begin
                            count <= sw_delay_i;
                            sel   <= ~sel;
                            state <= ST_SWITCH;
                        end else begin
                            count <= rx_delay_i;
                            state <= ST_RX_DELAY;
                        end
                    end
                end
                ST_SWITCH: begin
                    if (count != '0) begin
                        count <= count - DW'(1);
                    end else if (!tx_empty_i[sel]) begin
                        state   <= ST_TX;
                        grant_o <= sel ? 2'b10 : 2'b01;
                    end else begin
                        count <= rx_delay_i;
                        state <= ST_RX_DELAY;
                    end
                end
                ST_RX_DELAY: begin
                    if (count != '0) begin
                        count <= count - DW'(1);
                    end else begin
                        state    <= ST_RX;
                        atr_tx_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RX;
                    count    <= '0;
                    atr_tx_o <= 1'b0;
                    grant_o  <= 2'b00;
                end
            endcase
        end
    end

`ifdef ATR_SCHED_STATUS_EN
    logic enter_tx_c;

    // Edges on which the FSM moves into TX
    always_comb begin
        enter_tx_c = 1'b0;
        if (count == '0) begin
            if (state == ST_TX_DELAY) begin
                enter_tx_c = 1'b1;
            end else if (state == ST_SWITCH && !tx_empty_i[sel]) begin
                enter_tx_c = 1'b1;
            end
        end
    end

    // Burst counter, wrapping at its full width
    always_ff @(posedge clk_i) begin
        if (rst_i || !ena_i) begin
            burst_cnt_o <= '0;
        end else if (enter_tx_c) begin
            burst_cnt_o <= burst_cnt_o + BURST_W'(1);
        end
    end

    assign state_o = 3'(state);
`endif

endmodule
